// File: rtl/hex_fmt_pkg.sv
// Shared types and constants for the hex formatter arbiter and its helpers.
package hex_fmt_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  localparam int unsigned VALUE_W        = 64;
  localparam int unsigned DIGITS_W       = 8;
  localparam int unsigned DEFAULT_DIGITS = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request strictly after ptr_i, with wrap-around.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               found_o
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest asserted request wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      sum = {1'b0, ptr_i} + (IDX_W + 1)'(off);
      if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
        sum = sum - (IDX_W + 1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (req_i[cand]) begin
        idx_o   = cand;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hex_fmt_arbiter.sv
// Round-robin share of one 64-bit-to-ASCII-hex converter among NUM_REQ requesters.
// Optional converter watchdog with ERROR port: define HEX_ARB_TIMEOUT_EN.
module hex_fmt_arbiter
  import hex_fmt_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned OUTPUT_WIDTH   = 19,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [NUM_REQ-1:0]             REQ,
  input  logic [NUM_REQ*VALUE_W-1:0]     REQ_VALUE,
  input  logic [NUM_REQ*DIGITS_W-1:0]    REQ_DIGITS,
  input  logic [NUM_REQ-1:0]             REQ_NOSEP,
  output logic [NUM_REQ-1:0]             GRANT,
  output logic [NUM_REQ-1:0]             DONE,
`ifdef HEX_ARB_TIMEOUT_EN
  output logic [NUM_REQ-1:0]             ERROR,
`endif
  output logic [OUTPUT_WIDTH*8-1:0]      RESULT,
  output logic                           BUSY,
  output logic [VALUE_W-1:0]             CVT_VALUE,
  output logic [DIGITS_W-1:0]            CVT_DIGITS,
  output logic                           CVT_NOSEP,
  output logic                           CVT_START,
  input  logic [OUTPUT_WIDTH*8-1:0]      CVT_RESULT,
  input  logic                           CVT_IDLE
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned RES_W = OUTPUT_WIDTH * 8;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [RES_W-1:0]     result_q, result_d;
  logic                 busy_q, busy_d;
  logic [VALUE_W-1:0]   cvt_value_q, cvt_value_d;
  logic [DIGITS_W-1:0]  cvt_digits_q, cvt_digits_d;
  logic                 cvt_nosep_q, cvt_nosep_d;
  logic                 cvt_start_q, cvt_start_d;

`ifdef HEX_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   error_q, error_d;
`endif

  logic [IDX_W-1:0]     win_idx;
  logic                 win_found;
  logic [VALUE_W-1:0]   sel_value;
  logic [DIGITS_W-1:0]  sel_digits;
  logic                 sel_nosep;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i   (REQ),
    .ptr_i   (ptr_q),
    .idx_o   (win_idx),
    .found_o (win_found)
  );

  always_comb begin
    sel_value  = '0;
    sel_digits = '0;
    sel_nosep  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        sel_value  = REQ_VALUE[i*VALUE_W +: VALUE_W];
        sel_digits = REQ_DIGITS[i*DIGITS_W +: DIGITS_W];
        sel_nosep  = REQ_NOSEP[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    grant_d      = '0;
    done_d       = '0;
    result_d     = result_q;
    cvt_value_d  = cvt_value_q;
    cvt_digits_d = cvt_digits_q;
    cvt_nosep_d  = cvt_nosep_q;
    cvt_start_d  = 1'b0;
`ifdef HEX_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    error_d      = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        // A busy converter blocks arbitration entirely, so no grant is issued early.
        if (win_found && CVT_IDLE) begin
          idx_d        = win_idx;
          cvt_value_d  = sel_value;
          cvt_digits_d = sel_digits;
          cvt_nosep_d  = sel_nosep;
          cvt_start_d  = 1'b1;
          grant_d      = onehot(win_idx);
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        ptr_d   = idx_q;
        state_d = S_WAIT;
`ifdef HEX_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (CVT_IDLE) begin
          result_d = CVT_RESULT;
          done_d   = onehot(idx_q);
          state_d  = S_DONE;
        end
`ifdef HEX_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          error_d = onehot(idx_q);
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      ptr_q        <= IDX_W'(NUM_REQ - 1);
      idx_q        <= '0;
      grant_q      <= '0;
      done_q       <= '0;
      result_q     <= '0;
      busy_q       <= 1'b0;
      cvt_value_q  <= '0;
      cvt_digits_q <= '0;
      cvt_nosep_q  <= 1'b0;
      cvt_start_q  <= 1'b0;
`ifdef HEX_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      error_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      result_q     <= result_d;
      busy_q       <= busy_d;
      cvt_value_q  <= cvt_value_d;
      cvt_digits_q <= cvt_digits_d;
      cvt_nosep_q  <= cvt_nosep_d;
      cvt_start_q  <= cvt_start_d;
`ifdef HEX_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      error_q      <= error_d;
`endif
    end
  end

  assign GRANT      = grant_q;
  assign DONE       = done_q;
  assign RESULT     = result_q;
  assign BUSY       = busy_q;
  assign CVT_VALUE  = cvt_value_q;
  assign CVT_DIGITS = cvt_digits_q;
  assign CVT_NOSEP  = cvt_nosep_q;
  assign CVT_START  = cvt_start_q;
`ifdef HEX_ARB_TIMEOUT_EN
  assign ERROR      = error_q;
`endif

endmodule

// File: tb/tb_hex_fmt_arbiter.sv
// Directed + randomized bench for hex_fmt_arbiter with a converter model and a
// transaction-level scoreboard; HEX_ARB_TIMEOUT_EN also exercises the watchdog.
module tb_hex_fmt_arbiter;
  import hex_fmt_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned OW = 19;
  localparam int unsigned RW = OW * 8;
`ifdef HEX_ARB_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 64;
`endif

  logic            CLK = 1'b0;
  logic            RESET;
  logic [N-1:0]    REQ, REQ_NOSEP, GRANT, DONE;
  logic [N*64-1:0] REQ_VALUE;
  logic [N*8-1:0]  REQ_DIGITS;
  logic [RW-1:0]   RESULT, CVT_RESULT;
  logic            BUSY, CVT_NOSEP, CVT_START, CVT_IDLE;
  logic [63:0]     CVT_VALUE;
  logic [7:0]      CVT_DIGITS;
`ifdef HEX_ARB_TIMEOUT_EN
  logic [N-1:0]    ERROR;
`endif

  hex_fmt_arbiter #(
    .NUM_REQ        (N),
    .OUTPUT_WIDTH   (OW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .REQ        (REQ),
    .REQ_VALUE  (REQ_VALUE),
    .REQ_DIGITS (REQ_DIGITS),
    .REQ_NOSEP  (REQ_NOSEP),
    .GRANT      (GRANT),
    .DONE       (DONE),
`ifdef HEX_ARB_TIMEOUT_EN
    .ERROR      (ERROR),
`endif
    .RESULT     (RESULT),
    .BUSY       (BUSY),
    .CVT_VALUE  (CVT_VALUE),
    .CVT_DIGITS (CVT_DIGITS),
    .CVT_NOSEP  (CVT_NOSEP),
    .CVT_START  (CVT_START),
    .CVT_RESULT (CVT_RESULT),
    .CVT_IDLE   (CVT_IDLE)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference ASCII formatting: lowercase hex, ':' every 4 digits, right-aligned.
  function automatic logic [RW-1:0] fmt(input logic [63:0] v, input logic [7:0] d,
                                        input logic ns);
    int n, pos;
    logic [3:0] nib;
    logic [RW-1:0] r;
    n = (d == 0) ? int'(DEFAULT_DIGITS) : ((d > 16) ? 16 : int'(d));
    r = '0;
    pos = 0;
    for (int i = 0; i < n; i++) begin
      if (i != 0 && i % 4 == 0 && !ns) begin
        r[8*pos +: 8] = 8'h3a;
        pos++;
      end
      nib = v[4*i +: 4];
      r[8*pos +: 8] = (nib < 10) ? 8'(8'h30 + nib) : 8'(8'h57 + nib);
      pos++;
    end
    return r;
  endfunction

  // Converter model: busy for cvt_len cycles after a start, result ready when idle returns.
  logic        cvt_busy, hold_low;
  int          cvt_cnt, cvt_len;
  logic [63:0] cv;
  logic [7:0]  cd;
  logic        cn;
  assign CVT_IDLE = !cvt_busy && !CVT_START && !hold_low;

  always @(posedge CLK) begin
    if (RESET) begin
      cvt_busy   <= 1'b0;
      cvt_cnt    <= 0;
      CVT_RESULT <= '0;
    end else if (CVT_START) begin
      cvt_busy <= 1'b1;
      cvt_cnt  <= cvt_len;
      cv       <= CVT_VALUE;
      cd       <= CVT_DIGITS;
      cn       <= CVT_NOSEP;
    end else if (cvt_busy) begin
      if (cvt_cnt == 1) begin
        cvt_busy   <= 1'b0;
        CVT_RESULT <= fmt(cv, cd, cn);
      end
      cvt_cnt <= cvt_cnt - 1;
    end
  end

  // Scoreboard: predicts each cycle's outputs from the previous cycle's inputs.
  int            cyc = 0, g_cycle = 0, last = N - 1, job_idx = 0, pk = 0;
  int            grant_cnt[N], done_cnt = 0, err_cnt = 0;
  int            grant_log[$];
  bit            outstanding = 0, free_prev = 1, free_now = 1, finished = 0;
  bit            rst_prev = 1, idle_prev = 0;
  logic [N-1:0]  req_prev = '0, exp_grant, exp_done, exp_err;
  logic [N*64-1:0] rv_prev;
  logic [N*8-1:0]  rd_prev;
  logic [N-1:0]    rn_prev;
  logic [63:0]   job_val;
  logic [7:0]    job_dig;
  logic          job_ns;
  logic [RW-1:0] job_res, exp_res_held = '0;

  function automatic int pick(input logic [N-1:0] r, input int from);
    for (int off = 1; off <= N; off++) begin
      if (r[(from + off) % N]) return (from + off) % N;
    end
    return 0;
  endfunction

  always @(negedge CLK) begin
    cyc++;
    if (rst_prev) begin
      check_eq("rst_grant", GRANT, '0);
      check_eq("rst_done", DONE, '0);
      check_eq("rst_result", RESULT, '0);
      check_eq("rst_busy", BUSY, 0);
      check_eq("rst_cvt_value", CVT_VALUE, '0);
      check_eq("rst_cvt_digits", CVT_DIGITS, '0);
      check_eq("rst_cvt_nosep", CVT_NOSEP, 0);
      check_eq("rst_cvt_start", CVT_START, 0);
`ifdef HEX_ARB_TIMEOUT_EN
      check_eq("rst_error", ERROR, '0);
`endif
      outstanding  = 0;
      last         = N - 1;
      exp_res_held = '0;
      free_now     = 1;
    end else begin
      exp_grant = '0;
      if (free_prev && idle_prev && req_prev != 0) begin
        pk = pick(req_prev, last);
        exp_grant[pk] = 1'b1;
      end
      check_eq("grant", GRANT, exp_grant);
      check_eq("cvt_start", CVT_START, exp_grant != 0);
      if (exp_grant != 0) begin
        job_idx = pk;
        last    = pk;
        job_val = rv_prev[64*pk +: 64];
        job_dig = rd_prev[8*pk +: 8];
        job_ns  = rn_prev[pk];
        job_res = fmt(job_val, job_dig, job_ns);
        outstanding = 1;
        g_cycle = cyc;
        grant_cnt[pk]++;
        grant_log.push_back(pk);
        check_eq("cvt_value", CVT_VALUE, job_val);
        check_eq("cvt_digits", CVT_DIGITS, job_dig);
        check_eq("cvt_nosep", CVT_NOSEP, job_ns);
      end
      exp_done = '0;
      exp_err  = '0;
      if (outstanding && cyc - g_cycle >= 2) begin
        if (idle_prev) begin
          exp_done[job_idx] = 1'b1;
          exp_res_held = job_res;
          outstanding = 0;
          done_cnt++;
        end
`ifdef HEX_ARB_TIMEOUT_EN
        else if (cyc - g_cycle == int'(TO) + 1) begin
          exp_err[job_idx] = 1'b1;
          outstanding = 0;
          err_cnt++;
        end
`endif
      end
      finished = (exp_done | exp_err) != 0;
      check_eq("done", DONE, exp_done);
`ifdef HEX_ARB_TIMEOUT_EN
      check_eq("error", ERROR, exp_err);
`endif
      check_eq("result", RESULT, exp_res_held);
      check_eq("busy", BUSY, outstanding || finished);
      free_now = !outstanding && !finished;
    end
    free_prev = free_now;
    req_prev  = REQ;
    rv_prev   = REQ_VALUE;
    rd_prev   = REQ_DIGITS;
    rn_prev   = REQ_NOSEP;
    idle_prev = CVT_IDLE;
    rst_prev  = RESET;
  end

  // Stimulus helpers: inputs change 2 time units after the active edge.
  logic [N-1:0] keep;

  task automatic step();
    @(posedge CLK);
    #2;
    REQ = REQ & ~(GRANT & ~keep);
  endtask

  task automatic apply_reset();
    RESET = 1'b1;
    REQ = '0;
    hold_low = 1'b0;
    keep = '0;
    step();
    step();
    RESET = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [63:0] v, input logic [7:0] d,
                         input logic ns);
    REQ_VALUE[64*i +: 64] = v;
    REQ_DIGITS[8*i +: 8]  = d;
    REQ_NOSEP[i]          = ns;
    REQ[i]                = 1'b1;
  endtask

  task automatic wait_done(input logic [N-1:0] m, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while ((DONE & m) == 0 && n < budget);
    check_eq("done_wait", (DONE & m) != 0, 1);
  endtask

  task automatic wait_grant(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (GRANT == 0 && n < budget);
    check_eq("grant_wait", GRANT != 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (BUSY && n < budget) begin
      step();
      n++;
    end
    check_eq("idle_wait", BUSY, 0);
  endtask

  initial begin
    int n, g2_before, d_before;
    logic [RW-1:0] e1, r_saved;
    RESET = 1'b1;
    REQ = '0;
    REQ_VALUE = '0;
    REQ_DIGITS = '0;
    REQ_NOSEP = '0;
    keep = '0;
    hold_low = 1'b0;
    cvt_len = 8;
    for (int i = 0; i < N; i++) grant_cnt[i] = 0;
    repeat (3) step();
    RESET = 1'b0;
    step();

    // Single request, fixed latency and known string.
    set_req(0, 64'h0123_4567_89AB_CDEF, 8'd8, 1'b0);
    step();
    check_eq("t1_grant", GRANT, 4'b0001);
    wait_done(4'b0001, 30, n);
    check_eq("t1_latency", n, 10);
    e1 = '0;
    e1[71:0] = "89ab:cdef";
    check_eq("t1_result", RESULT, e1);
    step();

    // All requesters held high: rotation starts at 0 after reset.
    apply_reset();
    keep = '1;
    for (int i = 0; i < N; i++) set_req(i, 64'h1111_0000_0000_0000 * (i + 1) + i, 8'(4 * i + 4), i[0]);
    grant_log.delete();
    n = 0;
    while (grant_log.size() < 5 && n < 200) begin
      step();
      n++;
    end
    keep = '0;
    REQ = '0;
    check_eq("t2_count", grant_log.size() >= 5, 1);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) check_eq("t2_order", grant_log[i], i % 4);
    wait_idle(100);

    // Withdrawn request is never granted; newly raised one wins by pointer.
    apply_reset();
    cvt_len = 8;
    set_req(3, 64'hDEAD_BEEF, 8'd0, 1'b0);
    step();
    check_eq("t3_grant3", GRANT, 4'b1000);
    g2_before = grant_cnt[2];
    step();
    set_req(2, 64'h2222, 8'd4, 1'b1);
    step();
    REQ[2] = 1'b0;
    set_req(1, 64'h1234_5678, 8'd12, 1'b0);
    wait_done(4'b1000, 30, n);
    wait_grant(10);
    check_eq("t3_next", GRANT, 4'b0010);
    check_eq("t3_no2", grant_cnt[2] - g2_before, 0);
`ifdef HEX_ARB_TIMEOUT_EN
    check_eq("t3_no_err", err_cnt, 0);
`endif
    wait_done(4'b0010, 30, n);
    step();

    // Reset while waiting on the converter abandons the job.
    apply_reset();
    d_before = done_cnt;
    set_req(0, 64'hCAFE, 8'd16, 1'b0);
    step();
    check_eq("t4_grant", GRANT, 4'b0001);
    step();
    step();
    RESET = 1'b1;
    step();
    check_eq("t4_busy", BUSY, 0);
    check_eq("t4_done", DONE, '0);
    RESET = 1'b0;
    set_req(3, 64'hF00D_F00D, 8'd5, 1'b1);
    step();
    check_eq("t4_grant3", GRANT, 4'b1000);
    check_eq("t4_no_done", done_cnt - d_before, 0);
    wait_done(4'b1000, 30, n);
    step();

    // Converter not idle at request time: no grant until it is.
    hold_low = 1'b1;
    set_req(0, 64'h5555_AAAA, 8'd8, 1'b0);
    repeat (5) begin
      step();
      check_eq("t5_hold", GRANT, '0);
    end
    hold_low = 1'b0;
    step();
    check_eq("t5_grant", GRANT, 4'b0001);
    wait_done(4'b0001, 30, n);
    step();

`ifdef HEX_ARB_TIMEOUT_EN
    // Converter stall: ERROR 17 cycles after GRANT, RESULT held, no DONE.
    r_saved = RESULT;
    d_before = done_cnt;
    set_req(1, 64'h0BAD, 8'd8, 1'b0);
    step();
    check_eq("t6_grant", GRANT, 4'b0010);
    hold_low = 1'b1;
    n = 0;
    while (ERROR == 0 && n < 40) begin
      step();
      n++;
    end
    check_eq("t6_err", ERROR, 4'b0010);
    check_eq("t6_lat", n, 17);
    check_eq("t6_result", RESULT, r_saved);
    check_eq("t6_no_done", done_cnt - d_before, 0);
    hold_low = 1'b0;
    wait_idle(20);
    repeat (12) step();
`else
    r_saved = '0;
`endif

    // Randomized traffic.
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      cvt_len  = $urandom_range(1, 12);
      hold_low = ($urandom % 12 == 0);
      keep     = N'($urandom);
      for (int i = 0; i < N; i++) begin
        if (!REQ[i]) begin
          if ($urandom % 4 == 0)
            set_req(i, {$urandom, $urandom}, 8'($urandom_range(0, 16)), 1'($urandom));
        end else if ($urandom % 40 == 0 && !GRANT[i]) begin
          REQ[i] = 1'b0;
        end
      end
      step();
    end
    REQ = '0;
    hold_low = 1'b0;
    keep = '0;
    wait_idle(200);
    check_eq("rand_progress", done_cnt > 100, 1);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hex_fmt_arbiter.md
Name: hex_fmt_arbiter

Overview:
- Shares one 64-bit-to-ASCII-hex converter among NUM_REQ requesters (status reporters, debug UART formatters).
- Picks requesters round-robin, latches the winner's operands, pulses the converter's start, waits for the converter to report idle, then returns the ASCII result with a one-cycle done strobe to the winner.
- Sits between the requesters and a single converter instance; drives the converter through the CVT_* ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- OUTPUT_WIDTH, 19, number of 8-bit characters in the converter result.
- TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only when the optional feature is enabled.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- REQ  in  NUM_REQ  per-requester request level.
- REQ_VALUE  in  NUM_REQ*64  packed operands; requester i uses bits [64*i +: 64].
- REQ_DIGITS  in  NUM_REQ*8  digit count per requester; 0 means 8 digits (converter rule).
- REQ_NOSEP  in  NUM_REQ  per-requester "no ':' separators" flag.
- GRANT  out  NUM_REQ  one-hot, one-cycle pulse when a request is accepted.
- DONE  out  NUM_REQ  one-hot, one-cycle pulse when that requester's result is valid.
- ERROR  out  NUM_REQ  one-hot timeout pulse; present only with HEX_ARB_TIMEOUT_EN.
- RESULT  out  OUTPUT_WIDTH*8  last completed ASCII string; held until the next completion.
- BUSY  out  1  high in every state except S_IDLE.
- CVT_VALUE  out  64  operand to the converter.
- CVT_DIGITS  out  8  digit count to the converter.
- CVT_NOSEP  out  1  separator flag to the converter.
- CVT_START  out  1  converter start pulse.
- CVT_RESULT  in  OUTPUT_WIDTH*8  converter result.
- CVT_IDLE  in  1  converter idle; low during any cycle in which CVT_START is high.

Behaviour:
- Reset: all outputs are 0. The round-robin pointer is set to NUM_REQ-1, so requester 0 has first priority. State goes to S_IDLE. Reset mid-conversion abandons the job without issuing DONE; the converter must be reset by the same RESET.
- All outputs are registered.
- States:
  - S_IDLE: if |REQ and CVT_IDLE, choose the first asserted REQ searching from pointer+1 with wrap-around. Latch that requester's index, REQ_VALUE, REQ_DIGITS and REQ_NOSEP into the CVT_* registers. Go to S_ISSUE. If CVT_IDLE is low, wait; do not arbitrate.
  - S_ISSUE (exactly 1 cycle): CVT_START=1, GRANT[idx]=1, pointer<=idx. Go to S_WAIT.
  - S_WAIT: stay until CVT_IDLE=1, then capture CVT_RESULT into RESULT and go to S_DONE.
  - S_DONE (1 cycle): DONE[idx]=1 with RESULT already valid in the same cycle. Go to S_IDLE.
- Latency:
  - REQ sampled at cycle t gives GRANT at t+1.
  - Converter active from t+2.
  - CVT_IDLE first seen high at cycle w gives DONE at w+1.
  - Minimum turnaround between requests is 4 cycles, plus the converter run time.
- Requester protocol:
  - Hold REQ and the operands stable until GRANT; the operands may change afterwards.
  - Dropping REQ before GRANT withdraws the request with no side effects.
  - REQ still high during DONE counts as a new request, arbitrated at the next S_IDLE.
- Fairness: a requester just served has the lowest priority on the next arbitration. With all REQ held high the grant order is 0,1,2,3,0,...
- Simultaneous REQ edges: only the pointer determines the winner; no requester is dropped.
- Operand widths pass straight through unmodified; the arbiter does not interpret DIGITS.

Optional Feature:
- Macro: HEX_ARB_TIMEOUT_EN.
- Enabled:
  - An 8-bit-or-wider counter, width $clog2(TIMEOUT_CYCLES+1), clears at S_ISSUE and counts in S_WAIT.
  - Reaching TIMEOUT_CYCLES without CVT_IDLE goes to S_DONE, pulses ERROR[idx] instead of DONE[idx], and leaves RESULT unchanged.
  - S_IDLE still waits for CVT_IDLE before the next grant.
- Disabled: the ERROR port, counter and parameter usage are absent; S_WAIT waits indefinitely.

Decomposition:
- Package hex_fmt_pkg holds:
  - the state enum (S_IDLE, S_ISSUE, S_WAIT, S_DONE);
  - constants VALUE_W=64, DIGITS_W=8 and DEFAULT_DIGITS=8.
- Sub-module rr_arbiter(NUM_REQ): combinational winner index and found flag from REQ and the pointer. It is reusable elsewhere.

Test Plan:
- Single request: REQ[0]=1, VALUE=64'h0123_4567_89AB_CDEF, DIGITS=8, NOSEP=0 -> GRANT[0] at t+1, converter model runs 8 cycles. DONE[0] with RESULT low 9 chars "89ab:cdef", upper bytes 0.
- All four REQ held high, distinct values -> GRANT order 0,1,2,3,0. Each DONE[i] carries its own value and never overlaps another DONE.
- REQ[2] dropped at the same cycle REQ[1] rises while requester 3 is being served -> requester 1 is next; requester 2 is never granted; no ERROR.
- RESET asserted in S_WAIT -> next cycle all outputs 0, no DONE. After release, REQ[3] alone is granted within 1 cycle of sampling.
- CVT_IDLE held low at request time -> no GRANT until CVT_IDLE=1, then GRANT the following cycle.
- (HEX_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16) Converter stalls -> ERROR[idx] 17 cycles after GRANT, RESULT unchanged, no DONE.
